// File: rtl/sdrc_wb_pkg.sv
// Shared types for the SDRAM command tracker: command, bank state
// and error classes, plus the pin-level command decoder.
package sdrc_wb_pkg;

    typedef enum logic [2:0] {
        ACT, RD, WR, PRE, REF, MRS, BST, NOP
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE, ACTIVATING, ACTIVE, PRECHARGING
    } bank_state_e;

    typedef enum logic [2:0] {
        NO_ERR    = 3'd0,
        ACT_OPEN  = 3'd1,
        TRP       = 3'd2,
        TRCD      = 3'd3,
        RW_CLOSED = 3'd4,
        REF_OPEN  = 3'd5,
        PRE_INIT  = 3'd6
    } err_e;

    // {ras_n, cas_n, we_n} to command class
    function automatic cmd_e decode_cmd(input logic [2:0] rcw);
        cmd_e c;
        unique case (rcw)
            3'b011:  c = ACT;
            3'b101:  c = RD;
            3'b100:  c = WR;
            3'b010:  c = PRE;
            3'b001:  c = REF;
            3'b000:  c = MRS;
            3'b110:  c = BST;
            default: c = NOP;
        endcase
        return c;
    endfunction

    function automatic logic is_access(input cmd_e c);
        return (c == ACT) || (c == RD) || (c == WR);
    endfunction

endpackage

// File: rtl/sdrc_bank_fsm.sv
// One SDRAM bank: open/closed state, tRCD/tRP countdown and latched row.
// Reports its own error candidate for the command addressed to it.
module sdrc_bank_fsm
    import sdrc_wb_pkg::*;
#(
    parameter int ROW_W = 13,
    parameter int T_RCD = 3,
    parameter int T_RP  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_v,
    input  cmd_e             cmd,
    input  logic [ROW_W-1:0] row,
    input  logic             init_ok,
    output bank_state_e      state,
    output logic [ROW_W-1:0] open_row,
    output err_e             err
);

    localparam int TMAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] RCD_LD = TW'(T_RCD - 1);
    localparam logic [TW-1:0] RP_LD  = TW'(T_RP - 1);
    localparam logic [TW-1:0] ONE    = TW'(1);

    bank_state_e      st_q, st_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             go;

    always_comb begin
        err = NO_ERR;
        if (cmd_v) begin
            unique case (cmd)
                ACT: begin
                    if (st_q == ACTIVATING || st_q == ACTIVE)
                        err = ACT_OPEN;
                    else if (st_q == PRECHARGING)
                        err = TRP;
                end
                RD, WR: begin
                    if (st_q == ACTIVATING)
                        err = TRCD;
                    else if (st_q != ACTIVE)
                        err = RW_CLOSED;
                end
                default: ;
            endcase
        end
    end

    // An illegal or pre-init command leaves the bank untouched
    assign go = cmd_v && (err == NO_ERR) && (init_ok || cmd == PRE);

    always_comb begin
        st_d  = st_q;
        tmr_d = tmr_q;
        row_d = row_q;
        unique case (st_q)
            IDLE: begin
                if (go && cmd == ACT) begin
                    row_d = row;
                    if (T_RCD == 1) begin
                        st_d = ACTIVE;
                    end else begin
                        st_d  = ACTIVATING;
                        tmr_d = RCD_LD;
                    end
                end
            end
            ACTIVATING, ACTIVE: begin
                if (go && cmd == PRE) begin
                    if (T_RP == 1) begin
                        st_d  = IDLE;
                        tmr_d = '0;
                    end else begin
                        st_d  = PRECHARGING;
                        tmr_d = RP_LD;
                    end
                end else if (st_q == ACTIVATING) begin
                    if (tmr_q <= ONE) begin
                        st_d  = ACTIVE;
                        tmr_d = '0;
                    end else begin
                        tmr_d = tmr_q - ONE;
                    end
                end
            end
            PRECHARGING: begin
                if (tmr_q <= ONE) begin
                    st_d  = IDLE;
                    tmr_d = '0;
                end else begin
                    tmr_d = tmr_q - ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q  <= IDLE;
            tmr_q <= '0;
            row_q <= '0;
        end else begin
            st_q  <= st_d;
            tmr_q <= tmr_d;
            row_q <= row_d;
        end
    end

    assign state    = st_q;
    assign open_row = row_q;

endmodule

// File: rtl/sdrc_cmd_tracker.sv
// Whitebox SDRAM command tracker: decodes pin commands, tracks every
// bank, flags protocol violations and counts command classes.
module sdrc_cmd_tracker
    import sdrc_wb_pkg::*;
#(
    parameter int SDR_BANKS = 4,
    parameter int ROW_W     = 13,
    parameter int T_RCD     = 3,
    parameter int T_RP      = 3,
    parameter int CNT_W     = 16,
    localparam int BA_W     = $clog2(SDR_BANKS)
) (
    input  logic                       sdram_clk,
    input  logic                       sdram_reset,
    input  logic                       sdr_cke,
    input  logic                       sdr_cs_n,
    input  logic                       sdr_ras_n,
    input  logic                       sdr_cas_n,
    input  logic                       sdr_we_n,
    input  logic [BA_W-1:0]            sdr_ba,
    input  logic [12:0]                sdr_addr,
    input  logic                       sdr_init_done,
    input  logic                       cnt_clr,
    output logic [SDR_BANKS-1:0]       bank_open,
    output logic [SDR_BANKS*ROW_W-1:0] open_row,
    output logic [CNT_W-1:0]           cnt_act,
    output logic [CNT_W-1:0]           cnt_rd,
    output logic [CNT_W-1:0]           cnt_wr,
    output logic [CNT_W-1:0]           cnt_pre,
    output logic [CNT_W-1:0]           cnt_ref,
    output logic                       err_valid,
    output logic [2:0]                 err_code,
    output logic [BA_W-1:0]            err_bank,
    output logic                       err_sticky
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             v_q, a10_q, init_q, clr_q;
    cmd_e             cmd_q;
    logic [BA_W-1:0]  ba_q;
    logic [ROW_W-1:0] row_q;

    // Pins are registered first; all decisions use the captured command
    always_ff @(posedge sdram_clk or posedge sdram_reset) begin
        if (sdram_reset) begin
            v_q    <= 1'b0;
            cmd_q  <= NOP;
            ba_q   <= '0;
            row_q  <= '0;
            a10_q  <= 1'b0;
            init_q <= 1'b0;
            clr_q  <= 1'b0;
        end else begin
            v_q    <= sdr_cke & ~sdr_cs_n;
            cmd_q  <= decode_cmd({sdr_ras_n, sdr_cas_n, sdr_we_n});
            ba_q   <= sdr_ba;
            row_q  <= sdr_addr[ROW_W-1:0];
            a10_q  <= sdr_addr[10];
            init_q <= sdr_init_done;
            clr_q  <= cnt_clr;
        end
    end

    bank_state_e          bst  [SDR_BANKS];
    err_e                 berr [SDR_BANKS];
    logic [SDR_BANKS-1:0] hit;

    for (genvar b = 0; b < SDR_BANKS; b++) begin : g_bank
        assign hit[b] = v_q &&
            (ba_q == BA_W'(b) || (cmd_q == PRE && a10_q));

        sdrc_bank_fsm #(
            .ROW_W (ROW_W),
            .T_RCD (T_RCD),
            .T_RP  (T_RP)
        ) u_fsm (
            .clk      (sdram_clk),
            .rst      (sdram_reset),
            .cmd_v    (hit[b]),
            .cmd      (cmd_q),
            .row      (row_q),
            .init_ok  (init_q),
            .state    (bst[b]),
            .open_row (open_row[b*ROW_W +: ROW_W]),
            .err      (berr[b])
        );

        assign bank_open[b] = (bst[b] == ACTIVE);
    end

    logic            busy;
    logic [BA_W-1:0] low;

    always_comb begin
        busy = 1'b0;
        low  = '0;
        for (int b = SDR_BANKS - 1; b >= 0; b--) begin
            if (bst[b] != IDLE) begin
                busy = 1'b1;
                low  = BA_W'(b);
            end
        end
    end

    err_e            err_d;
    logic [BA_W-1:0] eb_d;

    always_comb begin
        err_d = NO_ERR;
        eb_d  = '0;
        if (v_q) begin
            if (is_access(cmd_q) && !init_q) begin
                err_d = PRE_INIT;
                eb_d  = ba_q;
            end else if (cmd_q == REF && busy) begin
                err_d = REF_OPEN;
                eb_d  = low;
            end else if (is_access(cmd_q)) begin
                err_d = berr[ba_q];
                eb_d  = ba_q;
            end
        end
    end

    logic [4:0]       inc;
    logic [CNT_W-1:0] cnt_q [5];

    assign inc = {v_q && cmd_q == REF,
                  v_q && cmd_q == PRE,
                  v_q && cmd_q == WR,
                  v_q && cmd_q == RD,
                  v_q && cmd_q == ACT};

    always_ff @(posedge sdram_clk or posedge sdram_reset) begin
        if (sdram_reset) begin
            for (int i = 0; i < 5; i++)
                cnt_q[i] <= '0;
            err_valid  <= 1'b0;
            err_code   <= 3'd0;
            err_bank   <= '0;
            err_sticky <= 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (clr_q)
                    cnt_q[i] <= '0;
                else if (inc[i] && cnt_q[i] != '1)
                    cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
            err_valid <= (err_d != NO_ERR);
            err_code  <= err_d;
            err_bank  <= eb_d;
            if (clr_q)
                err_sticky <= 1'b0;
            else if (err_d != NO_ERR)
                err_sticky <= 1'b1;
        end
    end

    assign cnt_act = cnt_q[0];
    assign cnt_rd  = cnt_q[1];
    assign cnt_wr  = cnt_q[2];
    assign cnt_pre = cnt_q[3];
    assign cnt_ref = cnt_q[4];

endmodule

// File: tb/tb_sdrc_cmd_tracker.sv
// Directed bench for sdrc_cmd_tracker with a time-stamp bank model
// compared every cycle, plus literal checkpoints along the sequence.
module tb_sdrc_cmd_tracker;

    localparam int NB   = 4;
    localparam int RW   = 13;
    localparam int TRCD = 3;
    localparam int TRP  = 3;
    localparam int CW   = 4;
    localparam int BW   = 2;
    localparam int CMAX = 15;

    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_NOP = 3'b111;

    localparam int S_IDLE = 0, S_ACTG = 1, S_ACTV = 2, S_PRCH = 3;

    logic          sdram_clk = 1'b0;
    logic          sdram_reset = 1'b1;
    logic          sdr_cke = 1'b1, sdr_cs_n = 1'b1;
    logic          sdr_ras_n = 1'b1, sdr_cas_n = 1'b1, sdr_we_n = 1'b1;
    logic [BW-1:0] sdr_ba = '0;
    logic [12:0]   sdr_addr = '0;
    logic          sdr_init_done = 1'b0, cnt_clr = 1'b0;

    logic [NB-1:0]    bank_open;
    logic [NB*RW-1:0] open_row;
    logic [CW-1:0]    cnt_act, cnt_rd, cnt_wr, cnt_pre, cnt_ref;
    logic             err_valid, err_sticky;
    logic [2:0]       err_code;
    logic [BW-1:0]    err_bank;

    sdrc_cmd_tracker #(
        .SDR_BANKS (NB), .ROW_W (RW), .T_RCD (TRCD),
        .T_RP (TRP), .CNT_W (CW)
    ) dut (
        .sdram_clk (sdram_clk), .sdram_reset (sdram_reset),
        .sdr_cke (sdr_cke), .sdr_cs_n (sdr_cs_n),
        .sdr_ras_n (sdr_ras_n), .sdr_cas_n (sdr_cas_n),
        .sdr_we_n (sdr_we_n), .sdr_ba (sdr_ba), .sdr_addr (sdr_addr),
        .sdr_init_done (sdr_init_done), .cnt_clr (cnt_clr),
        .bank_open (bank_open), .open_row (open_row),
        .cnt_act (cnt_act), .cnt_rd (cnt_rd), .cnt_wr (cnt_wr),
        .cnt_pre (cnt_pre), .cnt_ref (cnt_ref),
        .err_valid (err_valid), .err_code (err_code),
        .err_bank (err_bank), .err_sticky (err_sticky)
    );

    always #5 sdram_clk = ~sdram_clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    int          ecnt = 0;
    bit          m_open [NB];
    int          m_act  [NB];
    int          m_pre  [NB];
    logic [12:0] m_row  [NB];
    int          x_cnt  [5];
    bit          x_valid, x_sticky;
    int          x_code, x_bank;

    function automatic int mst(input int b, input int e);
        if (m_open[b])
            return (e - m_act[b] >= TRCD) ? S_ACTV : S_ACTG;
        return (e - m_pre[b] < TRP) ? S_PRCH : S_IDLE;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            m_open[b] = 0; m_act[b] = -100;
            m_pre[b] = -100; m_row[b] = '0;
        end
        for (int i = 0; i < 5; i++) x_cnt[i] = 0;
        x_valid = 0; x_sticky = 0; x_code = 0; x_bank = 0;
    endtask

    task automatic model_step();
        logic [2:0] rcw;
        int b, k, s, low;
        bit acc;
        rcw = {sdr_ras_n, sdr_cas_n, sdr_we_n};
        b = int'(sdr_ba);
        k = -1;
        x_valid = 0; x_code = 0; x_bank = 0;
        if (sdr_cke && !sdr_cs_n) begin
            case (rcw)
                C_ACT: k = 0;
                C_RD:  k = 1;
                C_WR:  k = 2;
                C_PRE: k = 3;
                C_REF: k = 4;
                default: k = -1;
            endcase
            acc = (k >= 0 && k <= 2);
            s = mst(b, ecnt);
            if (acc && !sdr_init_done) begin
                x_valid = 1; x_code = 6; x_bank = b;
            end else if (k == 4) begin
                low = -1;
                for (int j = NB - 1; j >= 0; j--)
                    if (mst(j, ecnt) != S_IDLE) low = j;
                if (low >= 0) begin
                    x_valid = 1; x_code = 5; x_bank = low;
                end
            end else if (k == 0) begin
                if (s == S_ACTG || s == S_ACTV) begin
                    x_valid = 1; x_code = 1; x_bank = b;
                end else if (s == S_PRCH) begin
                    x_valid = 1; x_code = 2; x_bank = b;
                end else begin
                    m_open[b] = 1; m_act[b] = ecnt; m_row[b] = sdr_addr;
                end
            end else if (k == 1 || k == 2) begin
                if (s == S_ACTG) begin
                    x_valid = 1; x_code = 3; x_bank = b;
                end else if (s != S_ACTV) begin
                    x_valid = 1; x_code = 4; x_bank = b;
                end
            end else if (k == 3) begin
                for (int j = 0; j < NB; j++) begin
                    if (j == b || sdr_addr[10]) begin
                        s = mst(j, ecnt);
                        if (s == S_ACTG || s == S_ACTV) begin
                            m_open[j] = 0; m_pre[j] = ecnt;
                        end
                    end
                end
            end
        end
        if (cnt_clr) begin
            for (int i = 0; i < 5; i++) x_cnt[i] = 0;
            x_sticky = 0;
        end else begin
            if (k >= 0 && x_cnt[k] < CMAX) x_cnt[k]++;
            if (x_valid) x_sticky = 1;
        end
    endtask

    task automatic compare();
        logic [NB-1:0]    eo;
        logic [NB*RW-1:0] er;
        for (int b = 0; b < NB; b++) begin
            eo[b] = m_open[b] && (ecnt - m_act[b] >= TRCD);
            er[b*RW +: RW] = m_row[b];
        end
        chk("m_bank_open", bank_open, eo);
        chk("m_open_row", open_row, er);
        chk("m_cnt_act", cnt_act, x_cnt[0]);
        chk("m_cnt_rd", cnt_rd, x_cnt[1]);
        chk("m_cnt_wr", cnt_wr, x_cnt[2]);
        chk("m_cnt_pre", cnt_pre, x_cnt[3]);
        chk("m_cnt_ref", cnt_ref, x_cnt[4]);
        chk("m_err_valid", err_valid, x_valid);
        if (x_valid) begin
            chk("m_err_code", err_code, x_code);
            chk("m_err_bank", err_bank, x_bank);
        end
        chk("m_err_sticky", err_sticky, x_sticky);
    endtask

    always @(posedge sdram_clk) begin
        #1;
        ecnt++;
        if (sdram_reset) model_reset();
        compare();
        if (!sdram_reset) model_step();
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [2:0] rcw, input int b,
                         input logic [12:0] a, input logic c = 1'b0);
        sdr_cs_n = 1'b0;
        {sdr_ras_n, sdr_cas_n, sdr_we_n} = rcw;
        sdr_ba = BW'(b);
        sdr_addr = a;
        cnt_clr = c;
        @(negedge sdram_clk);
        sdr_cs_n = 1'b1;
        {sdr_ras_n, sdr_cas_n, sdr_we_n} = C_NOP;
        cnt_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sdram_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        sdr_init_done = 1'b1;
        idle(3);
        chk("rst_bank_open", bank_open, 0);
        chk("rst_cnt_act", cnt_act, 0);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_err_sticky", err_sticky, 0);
        sdram_reset = 1'b0;
        idle(1);

        // ACT then RD exactly tRCD later
        issue(C_ACT, 0, 13'h123);
        idle(2);
        issue(C_RD, 0, 13'h0);
        idle(1);
        chk("t1_err_valid", err_valid, 0);
        chk("t1_bank_open", bank_open, 4'b0001);
        chk("t1_open_row0", open_row[RW-1:0], 13'h123);
        chk("t1_cnt_act", cnt_act, 1);
        chk("t1_cnt_rd", cnt_rd, 1);

        // WR too early after ACT
        issue(C_ACT, 2, 13'h2AA);
        idle(1);
        issue(C_WR, 2, 13'h0);
        idle(1);
        chk("t2_err_valid", err_valid, 1);
        chk("t2_err_code", err_code, 3);
        chk("t2_err_bank", err_bank, 2);
        chk("t2_sticky", err_sticky, 1);
        idle(1);
        chk("t2_pulse_end", err_valid, 0);

        // ACT inside and at the tRP boundary
        issue(C_ACT, 1, 13'h0B1);
        idle(3);
        issue(C_PRE, 1, 13'h0);
        idle(1);
        issue(C_ACT, 1, 13'h0B1);
        issue(C_ACT, 1, 13'h0B2);
        chk("t3_err_valid", err_valid, 1);
        chk("t3_err_code", err_code, 2);
        chk("t3_err_bank", err_bank, 1);
        idle(1);
        chk("t3_legal_act", err_valid, 0);

        // REF with banks 0 and 3 open, then after PRE-ALL
        issue(C_PRE, 1, 13'h0);
        issue(C_PRE, 2, 13'h0);
        issue(C_ACT, 3, 13'h3C3);
        idle(4);
        issue(C_REF, 0, 13'h0);
        idle(1);
        chk("t4_bank_open", bank_open, 4'b1001);
        chk("t4_err_valid", err_valid, 1);
        chk("t4_err_code", err_code, 5);
        chk("t4_err_bank", err_bank, 0);
        chk("t4_cnt_ref", cnt_ref, 1);
        issue(C_PRE, 0, 13'h400);
        idle(2);
        issue(C_REF, 0, 13'h0);
        idle(1);
        chk("t4_ref_ok", err_valid, 0);
        chk("t4_cnt_ref2", cnt_ref, 2);
        chk("t4_all_closed", bank_open, 0);

        // counter saturation and clear priority
        issue(C_NOP, 0, 13'h0, 1'b1);
        for (int i = 0; i < 17; i++) begin
            issue(C_ACT, 0, 13'(i));
            issue(C_PRE, 0, 13'h0);
            idle(2);
        end
        chk("t5_cnt_act_sat", cnt_act, 15);
        chk("t5_cnt_pre_sat", cnt_pre, 15);
        chk("t5_cnt_rd_clr", cnt_rd, 0);
        chk("t5_sticky_clr", err_sticky, 0);
        issue(C_ACT, 0, 13'h0AB, 1'b1);
        idle(1);
        chk("t5_clr_wins", cnt_act, 0);
        chk("t5_no_err", err_valid, 0);

        // access before init done, overlapping a tRCD violation
        sdr_init_done = 1'b0;
        issue(C_RD, 0, 13'h0);
        idle(1);
        chk("t6_err_valid", err_valid, 1);
        chk("t6_err_code", err_code, 6);
        chk("t6_err_bank", err_bank, 0);
        chk("t6_cnt_rd", cnt_rd, 1);

        // async reset while bank 0 is activating
        sdr_init_done = 1'b1;
        issue(C_PRE, 0, 13'h0);
        idle(3);
        issue(C_ACT, 0, 13'h077);
        idle(1);
        chk("t7_pre_row", open_row[RW-1:0], 13'h077);
        chk("t7_pre_sticky", err_sticky, 1);
        #2 sdram_reset = 1'b1;
        #1;
        chk("t7_bank_open", bank_open, 0);
        chk("t7_open_row", open_row, 0);
        chk("t7_cnt_act", cnt_act, 0);
        chk("t7_cnt_rd", cnt_rd, 0);
        chk("t7_cnt_wr", cnt_wr, 0);
        chk("t7_cnt_pre", cnt_pre, 0);
        chk("t7_cnt_ref", cnt_ref, 0);
        chk("t7_err_valid", err_valid, 0);
        chk("t7_err_code", err_code, 0);
        chk("t7_err_bank", err_bank, 0);
        chk("t7_err_sticky", err_sticky, 0);
        idle(2);
        sdram_reset = 1'b0;
        idle(4);
        chk("t7_stays_idle", bank_open, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
